// File: rtl/neuron_volley_gen.sv
// neuron_volley_gen
// One layer of integrate-and-fire neurons evaluated over a gamma window of
// GAMMA_PERIOD sampled cycles. Each neuron accumulates the weights of the
// active input spikes. It fires once, one cycle after its potential first
// reaches THRESHOLD. After firing it stops integrating for the rest of the
// window. time_val tags each output cycle with the window-relative sample
// time. It reads all-ones whenever no window output is pending.
//
// Optional feature: define NEURON_LEAK_EN to enable leak. With leak, a
// non-fired neuron that sees zero summed input in a RUN cycle loses one unit
// of potential, floored at zero. When the macro is undefined, potential never
// decreases within a window.
module neuron_volley_gen #(
  parameter int NUM_NEURONS  = 16,
  parameter int NUM_INPUTS   = 16,
  parameter int WEIGHT_W     = 3,
  parameter int THRESHOLD    = 8,
  parameter int GAMMA_PERIOD = 16
) (
  input  logic                                        clk,
  input  logic                                        rst_l,
  input  logic                                        start,
  input  logic [NUM_INPUTS-1:0]                       input_spikes,
  input  logic [NUM_NEURONS*NUM_INPUTS*WEIGHT_W-1:0]  weights,
  output logic [NUM_NEURONS-1:0]                      spike_volley,
  output logic [$clog2(GAMMA_PERIOD):0]               time_val,
  output logic                                        busy,
  output logic                                        volley_done
);

  localparam int TV_W    = $clog2(GAMMA_PERIOD) + 1;
  localparam int W_MAX   = (1 << WEIGHT_W) - 1;
  // Worst case: every input active with maximum weight for the whole window.
  localparam int POT_MAX = NUM_INPUTS * GAMMA_PERIOD * W_MAX;
  localparam int POT_W   = (POT_MAX < 1) ? 1 : $clog2(POT_MAX + 1);
  localparam logic [TV_W-1:0] T_LAST = TV_W'(GAMMA_PERIOD - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t                 r_state;
  logic [TV_W-1:0]        r_t;
  logic [POT_W-1:0]       r_pot [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] r_fired;

  // Output stage: one cycle behind the sampling cycle.
  logic [NUM_NEURONS-1:0] r_spike_p1;
  logic [TV_W-1:0]        r_tval_p1;
  logic                   r_busy;
  logic                   r_done_p1;

  logic [POT_W-1:0]       w_sum     [NUM_NEURONS];
  logic [POT_W-1:0]       w_pot_nxt [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] w_cross;

  // Threshold test done in 64 bits so THRESHOLD may exceed the potential range.
  function automatic logic f_reaches(input logic [POT_W-1:0] p);
    return (64'(p) >= 64'(THRESHOLD));
  endfunction

`ifdef NEURON_LEAK_EN
  // Leak by one unit, saturating at zero.
  function automatic logic [POT_W-1:0] f_leak_floor(input logic [POT_W-1:0] p);
    return (p == '0) ? '0 : (p - POT_W'(1));
  endfunction
`endif

  // Stage p0: weighted sum of the active inputs for every neuron.
  always_comb begin
    for (int n = 0; n < NUM_NEURONS; n++) begin
      w_sum[n] = '0;
      for (int j = 0; j < NUM_INPUTS; j++) begin
        if (input_spikes[j]) begin
          w_sum[n] = w_sum[n] + POT_W'(weights[(n*NUM_INPUTS+j)*WEIGHT_W +: WEIGHT_W]);
        end
      end
    end
  end

  // Updated potential and first-crossing detection for non-fired neurons.
  always_comb begin
    for (int n = 0; n < NUM_NEURONS; n++) begin
      w_pot_nxt[n] = r_pot[n] + w_sum[n];
`ifdef NEURON_LEAK_EN
      if (w_sum[n] == '0) begin
        w_pot_nxt[n] = f_leak_floor(r_pot[n]);
      end
`endif
      w_cross[n] = !r_fired[n] && f_reaches(w_pot_nxt[n]);
    end
  end

  // Window FSM: integration state plus the registered output stage.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_state    <= S_IDLE;
      r_t        <= '0;
      r_fired    <= '0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
        r_pot[n] <= '0;
      end
      r_spike_p1 <= '0;
      r_tval_p1  <= '1;
      r_busy     <= 1'b0;
      r_done_p1  <= 1'b0;
    end else begin
      r_spike_p1 <= '0;
      r_tval_p1  <= '1;
      r_done_p1  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_t     <= '0;
            r_fired <= '0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
              r_pot[n] <= '0;
            end
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          // start is ignored here; the window always runs to completion.
          for (int n = 0; n < NUM_NEURONS; n++) begin
            if (!r_fired[n]) begin
              r_pot[n] <= w_pot_nxt[n];
              if (w_cross[n]) begin
                r_fired[n] <= 1'b1;
              end
            end
          end
          // Stage p1 boundary: fire pulses and time tag of this sample.
          r_spike_p1 <= w_cross;
          r_tval_p1  <= r_t;
          if (r_t == T_LAST) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done_p1 <= 1'b1;
          end else begin
            r_t <= r_t + TV_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign spike_volley = r_spike_p1;
  assign time_val     = r_tval_p1;
  assign busy         = r_busy;
  assign volley_done  = r_done_p1;

endmodule
